inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/pic_pkg.sv | 30 +++
 rtl/sync2.sv | 31 +++
 rtl/inta_sequencer.sv | 178 +++++++++++++++++
 tb/tb_inta_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the INTA sequencer that talks to an 8259-style PIC:
//   - state_t       : FSM state encoding
//   - DEF_PULSE_W   : default INTA low time in clk cycles
//   - DEF_GAP_W     : default INTA high time between/after pulses in clk cycles
//   - DEF_TIMEOUT   : default HOLD watchdog limit in clk cycles
//   - load_of()     : converts a phase length into the down-counter reload value
// -----------------------------------------------------------------------------
package pic_pkg;

    localparam int DEF_PULSE_W = 2;
    localparam int DEF_GAP_W   = 2;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P1_LOW  = 3'd1,
        ST_P1_GAP  = 3'd2,
        ST_P2_LOW  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    // The phase counter counts down to zero, so an N-cycle phase loads N-1.
    function automatic logic [3:0] load_of(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both flops to 0
//   d    - asynchronous input level
//   q    - synchronized level (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q sample together at the
    // edge; blocking ones here would collapse the chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
// Issues the two-pulse INTA handshake to an 8259-style PIC when INT rises,
// captures the vector returned on the second pulse and hands it to the CPU
// with a valid/ready handshake.
//
// Parameters:
//   PULSE_W  - INTA low time in clk cycles (1..15)
//   GAP_W    - INTA high time between/after pulses in clk cycles (1..15)
//   TIMEOUT  - HOLD watchdog limit in clk cycles (1..255)
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - asynchronous active-high reset
//   int_in    - INT from the PIC, asynchronous to clk
//   data_in   - PIC data bus
//   inta_n    - INTA strobe to the PIC, active-low, registered
//   vec_valid - captured vector available
//   vec_data  - captured interrupt vector
//   vec_ready - CPU accepts the vector
//   busy      - high in every state except IDLE
//   err       - one-cycle pulse when the HOLD watchdog expires
//
// Build option:
//   INTA_SEQ_TIMEOUT_EN - when defined, a watchdog abandons an unaccepted
//                         vector after TIMEOUT cycles in HOLD and pulses err.
//                         When undefined, HOLD waits indefinitely and err is 0.
// -----------------------------------------------------------------------------
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_in,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    output logic       busy,
    output logic       err
);

    if (PULSE_W < 1 || PULSE_W > 15) begin : g_pulse_w_check
        $error("PULSE_W must be in 1..15");
    end
    if (GAP_W < 1 || GAP_W > 15) begin : g_gap_w_check
        $error("GAP_W must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_check
        $error("TIMEOUT must be in 1..255");
    end

    localparam logic [3:0] PULSE_LD = load_of(PULSE_W);
    localparam logic [3:0] GAP_LD   = load_of(GAP_W);

    state_t     state;
    logic [3:0] cnt;
    logic       int_s;

`ifdef INTA_SEQ_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd;
    logic       err_q;
`endif

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (int_in),
        .q   (int_s)
    );

    // inta_n is driven from the same flop stage as the state so the strobe is
    // glitch-free and the async reset releases it to 1 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            inta_n    <= 1'b1;
            vec_valid <= 1'b0;
            vec_data  <= 8'h00;
`ifdef INTA_SEQ_TIMEOUT_EN
            wd        <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef INTA_SEQ_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (int_s) begin
                        state  <= ST_P1_LOW;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                    end
                end
                // Once started, both pulses are always issued even if INT
                // drops, so the PIC can complete with its spurious vector.
                ST_P1_LOW: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_P1_GAP;
                        cnt    <= GAP_LD;
                        inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_P1_GAP: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_P2_LOW;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_P2_LOW: begin
                    if (cnt == 4'd0) begin
                        // Last low cycle: the PIC is driving the vector now.
                        state     <= ST_HOLD;
                        cnt       <= '0;
                        inta_n    <= 1'b1;
                        vec_data  <= data_in;
                        vec_valid <= 1'b1;
`ifdef INTA_SEQ_TIMEOUT_EN
                        wd        <= '0;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (vec_valid && vec_ready) begin
                        state     <= ST_RECOVER;
                        cnt       <= GAP_LD;
                        vec_valid <= 1'b0;
                    end
`ifdef INTA_SEQ_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        state     <= ST_RECOVER;
                        cnt       <= GAP_LD;
                        vec_valid <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
`endif
                end
                ST_RECOVER: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    inta_n <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef INTA_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_sequencer
// Self-checking bench for inta_sequencer (PULSE_W=2, GAP_W=2, TIMEOUT=4).
// A timeline model derives the expected outputs from the number of edges
// since a sequence started; directed scenarios compare against constants.
// -----------------------------------------------------------------------------
module tb_inta_sequencer;

    localparam int PW = 2;
    localparam int GW = 2;
    localparam int TO = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       int_in    = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       vec_ready = 1'b0;
    logic       inta_n;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       busy;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    inta_sequencer #(
        .PULSE_W (PW),
        .GAP_W   (GW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .int_in    (int_in),
        .data_in   (data_in),
        .inta_n    (inta_n),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .busy      (busy),
        .err       (err)
    );

    // ---------------------------------------------------------------- model
    // Timeline view: after a start edge (t=0) INTA is low for t in [0,PW),
    // high for [PW,PW+GW), low for [PW+GW,2PW+GW); the vector lands at
    // t=2PW+GW. Recovery lasts GW edges after acceptance.
    typedef enum int {M_IDLE, M_SEQ, M_HOLD, M_RECOVER} mphase_t;

    mphase_t    m_phase   = M_IDLE;
    int         m_t       = 0;
    logic       m_s1      = 1'b0;
    logic       m_s2      = 1'b0;
    logic       m_int_old = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_err   = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_inta_n;
    logic       exp_busy;
`ifdef INTA_SEQ_TIMEOUT_EN
    int         m_w       = 0;
`endif

    assign exp_inta_n = !(m_phase == M_SEQ && (m_t < PW || m_t >= PW + GW));
    assign exp_busy   = (m_phase != M_IDLE);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   = M_IDLE;
            m_t       = 0;
            m_s1      = 1'b0;
            m_s2      = 1'b0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_data  = 8'h00;
        end else begin
            m_int_old = m_s2;
            m_s2      = m_s1;
            m_s1      = int_in;
            exp_err   = 1'b0;
            case (m_phase)
                M_IDLE: if (m_int_old) begin
                    m_phase = M_SEQ;
                    m_t     = 0;
                end
                M_SEQ: begin
                    m_t++;
                    if (m_t == 2 * PW + GW) begin
                        m_phase   = M_HOLD;
                        exp_valid = 1'b1;
                        exp_data  = data_in;
`ifdef INTA_SEQ_TIMEOUT_EN
                        m_w       = 0;
`endif
                    end
                end
                M_HOLD: begin
                    if (vec_ready) begin
                        m_phase   = M_RECOVER;
                        m_t       = 0;
                        exp_valid = 1'b0;
                    end
`ifdef INTA_SEQ_TIMEOUT_EN
                    else begin
                        m_w++;
                        if (m_w == TO) begin
                            m_phase   = M_RECOVER;
                            m_t       = 0;
                            exp_valid = 1'b0;
                            exp_err   = 1'b1;
                        end
                    end
`endif
                end
                M_RECOVER: begin
                    m_t++;
                    if (m_t == GW) m_phase = M_IDLE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- utils
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drains any pending vector and waits for a quiet IDLE with int_s low.
    task automatic settle();
        int quiet = 0;
        int_in    = 1'b0;
        vec_ready = 1'b0;
        for (int c = 0; c < 100 && quiet < 4; c++) begin
            step();
            vec_ready = vec_valid;
            quiet     = busy ? 0 : quiet + 1;
        end
        vec_ready = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL settle_idle: busy=%b required 0", busy);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst       = 1'b1;
        int_in    = 1'b1;
        data_in   = 8'hA5;
        vec_ready = 1'b1;
        repeat (3) step();
        n_total++;
        if ({inta_n, vec_valid, vec_data, busy, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_values: got inta_n=%b valid=%b data=%h busy=%b err=%b",
                     inta_n, vec_valid, vec_data, busy, err);
        else n_pass++;
        int_in    = 1'b0;
        vec_ready = 1'b0;
    endtask

    task automatic test_basic();
        rst     = 1'b0;
        int_in  = 1'b1;
        data_in = 8'h11;
        for (int n = 1; n <= 9; n++) begin
            logic want_low;
            step();
            want_low = (n == 3 || n == 4 || n == 7 || n == 8);
            n_total++;
            if (inta_n !== !want_low)
                $display("FAIL basic_inta_edge%0d: inta_n=%b required %b", n, inta_n, !want_low);
            else n_pass++;
            if (n == 6) data_in = 8'h75;
        end
        n_total++;
        if ({vec_valid, vec_data, busy} !== {1'b1, 8'h75, 1'b1})
            $display("FAIL basic_capture: valid=%b data=%h busy=%b required 1 75 1",
                     vec_valid, vec_data, busy);
        else n_pass++;
        data_in = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if ({vec_valid, vec_data, inta_n} !== {1'b1, 8'h75, 1'b1})
                $display("FAIL basic_hold%0d: valid=%b data=%h inta_n=%b required 1 75 1",
                         i, vec_valid, vec_data, inta_n);
            else n_pass++;
        end
        vec_ready = 1'b1;
        int_in    = 1'b0;
        step();
        vec_ready = 1'b0;
        n_total++;
        if ({vec_valid, busy} !== 2'b01)
            $display("FAIL basic_accept: valid=%b busy=%b required 0 1", vec_valid, busy);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b1) $display("FAIL basic_recover: busy=%b required 1", busy);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL basic_idle: busy=%b required 0", busy);
        else n_pass++;
        settle();
    endtask

    task automatic test_int_drop();
        int_in  = 1'b1;
        data_in = 8'h00;
        for (int n = 1; n <= 9; n++) begin
            logic want_low;
            step();
            want_low = (n == 3 || n == 4 || n == 7 || n == 8);
            n_total++;
            if (inta_n !== !want_low)
                $display("FAIL drop_inta_edge%0d: inta_n=%b required %b", n, inta_n, !want_low);
            else n_pass++;
            if (n == 5) int_in = 1'b0;
            if (n == 6) data_in = 8'h77;
        end
        n_total++;
        if ({vec_valid, vec_data} !== {1'b1, 8'h77})
            $display("FAIL drop_vector: valid=%b data=%h required 1 77", vec_valid, vec_data);
        else n_pass++;
        data_in = 8'h00;
        settle();
    endtask

    task automatic test_back_to_back();
        int   accepted = 0;
        int   falls    = 0;
        int   delay    = -1;
        logic prev     = 1'b1;
        int_in = 1'b1;
        for (int c = 0; c < 400; c++) begin
            data_in = 8'($urandom);
            step();
            if (prev && !inta_n) falls++;
            prev = inta_n;
            if (vec_ready) begin
                accepted++;
                vec_ready = 1'b0;
            end else if (vec_valid) begin
                if (delay < 0) delay = int'($urandom_range(0, 3));
                if (delay == 0) begin
                    vec_ready = 1'b1;
                    delay     = -1;
                    if (accepted == 2) int_in = 1'b0;
                end else begin
                    delay--;
                end
            end
            if (accepted == 3 && !busy) break;
        end
        repeat (6) begin
            step();
            if (prev && !inta_n) falls++;
            prev = inta_n;
        end
        n_total++;
        if (accepted !== 3) $display("FAIL b2b_accepted: got %0d required 3", accepted);
        else n_pass++;
        n_total++;
        if (falls !== 6) $display("FAIL b2b_pulses: got %0d required 6", falls);
        else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid();
        int_in = 1'b1;
        repeat (7) step();
        n_total++;
        if (inta_n !== 1'b0) $display("FAIL rstmid_in_p2: inta_n=%b required 0", inta_n);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({inta_n, vec_valid, vec_data, busy, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL rstmid_async: got inta_n=%b valid=%b data=%h busy=%b err=%b",
                     inta_n, vec_valid, vec_data, busy, err);
        else n_pass++;
        int_in = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if ({vec_valid, inta_n, busy} !== 3'b010)
                $display("FAIL rstmid_after%0d: valid=%b inta_n=%b busy=%b required 0 1 0",
                         i, vec_valid, inta_n, busy);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int seen = 0;
        int_in  = 1'b1;
        data_in = 8'h5A;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            if (vec_valid) seen = 1;
        end
        int_in  = 1'b0;
        data_in = 8'h00;
        n_total++;
        if (seen !== 1) $display("FAIL timeout_hold_entry: valid never rose within 30 cycles");
        else n_pass++;
`ifdef INTA_SEQ_TIMEOUT_EN
        begin
            int   first_err = 0;
            int   err_cycles = 0;
            logic valid_at_err = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (err) begin
                    err_cycles++;
                    if (first_err == 0) begin
                        first_err    = i;
                        valid_at_err = vec_valid;
                    end
                end
            end
            n_total++;
            if (first_err !== TO) $display("FAIL timeout_delay: err at +%0d required +%0d", first_err, TO);
            else n_pass++;
            n_total++;
            if (err_cycles !== 1) $display("FAIL timeout_width: err for %0d cycles required 1", err_cycles);
            else n_pass++;
            n_total++;
            if (valid_at_err !== 1'b0) $display("FAIL timeout_valid: valid=%b required 0", valid_at_err);
            else n_pass++;
        end
`else
        begin
            int bad_valid = 0;
            int bad_err   = 0;
            repeat (1000) begin
                step();
                if (vec_valid !== 1'b1 || vec_data !== 8'h5A) bad_valid++;
                if (err !== 1'b0) bad_err++;
            end
            n_total++;
            if (bad_valid !== 0) $display("FAIL hold_forever_valid: %0d bad cycles required 0", bad_valid);
            else n_pass++;
            n_total++;
            if (bad_err !== 0) $display("FAIL hold_forever_err: %0d err cycles required 0", bad_err);
            else n_pass++;
        end
`endif
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) int_in = ~int_in;
            vec_ready = ($urandom_range(0, 3) == 0);
            data_in   = 8'($urandom);
            rst       = (c == 400);
            step();
            n_total++;
            if ({inta_n, vec_valid, busy, err, vec_data} !==
                {exp_inta_n, exp_valid, exp_busy, exp_err, exp_data})
                $display("FAIL random_c%0d: got inta_n=%b valid=%b busy=%b err=%b data=%h required %b %b %b %b %h",
                         c, inta_n, vec_valid, busy, err, vec_data,
                         exp_inta_n, exp_valid, exp_busy, exp_err, exp_data);
            else n_pass++;
        end
        rst = 1'b0;
        settle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_int_drop();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
